// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULTU = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_DIVU  = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MADDU = 3'b110,
    MDU_MADD  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int mdu_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder, keep the difference when it does not go negative.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] diff;

  // Trial subtraction; the borrow bit decides the quotient bit.
  assign diff    = rem_in - {1'b0, divisor};
  assign qbit    = ~diff[WIDTH];
  assign rem_out = qbit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Radix-2 shift-add
// multiply and restoring divide, one bit per cycle, on sign magnitudes;
// signs are re-applied in the FIX cycle together with the HI/LO write-back.
// Optional MDU_MADD_EN enables MADDU/MADD ({Hi,Lo} += product).
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = mdu_cnt_w(WIDTH);

  mdu_state_e         state;
  mdu_op_e            op;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // {partial hi / remainder, multiplier / dividend->quotient}
  logic [WIDTH-1:0]   b;     // multiplicand or divisor magnitude
  logic               neg_q, neg_r, dz;

  mdu_op_e          req;
  logic             req_iter, a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign req    = mdu_op_e'(MDOp);
  assign a_neg  = MDOp[0] & SrcA[WIDTH-1];
  assign b_neg  = MDOp[0] & SrcB[WIDTH-1];
  assign a_mag  = a_neg ? -SrcA : SrcA;
  assign b_mag  = b_neg ? -SrcB : SrcB;
  assign is_div = (op == MDU_DIVU) || (op == MDU_DIV);

`ifdef MDU_MADD_EN
  assign req_iter = ~MDOp[2] | MDOp[1];
`else
  assign req_iter = ~MDOp[2];
`endif

  // Per-cycle step for both operations.
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   drem;
  logic               dbit;
  logic [2*WIDTH-1:0] next_iter;

  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
    .divisor (b),
    .rem_out (drem),
    .qbit    (dbit)
  );

  assign next_iter = is_div ? {drem, acc[WIDTH-2:0], dbit}
                            : {msum, acc[WIDTH-1:1]};

  // Sign fix-up and write-back value used in FIX.
  logic [2*WIDTH-1:0] prod, wb_mul, wb;
  logic [WIDTH-1:0]   quo, rmd, wb_lo, wb_hi;

  assign prod = neg_q ? -acc : acc;
`ifdef MDU_MADD_EN
  logic madd;
  assign madd   = (op == MDU_MADDU) || (op == MDU_MADD);
  assign wb_mul = madd ? prod + {Hi, Lo} : prod;
`else
  assign wb_mul = prod;
`endif
  assign quo   = acc[WIDTH-1:0];
  assign rmd   = acc[2*WIDTH-1:WIDTH];
  // Divide by zero: quotient forced to all ones; the remainder naturally
  // ends up as the dividend, so Hi returns SrcA after the sign fix.
  assign wb_lo = dz ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
  assign wb_hi = neg_r ? -rmd : rmd;
  assign wb    = is_div ? {wb_hi, wb_lo} : wb_mul;

  // Control FSM with registered Busy/Done and HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= MDU_MULTU;
      cnt   <= '0;
      acc   <= '0;
      b     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            if (req == MDU_MTHI) begin
              Hi <= SrcA;
            end else if (req == MDU_MTLO) begin
              Lo <= SrcA;
            end else if (req_iter) begin
              op    <= req;
              acc   <= {{WIDTH{1'b0}}, a_mag};
              b     <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              dz    <= (SrcB == '0);
              cnt   <= CW'(WIDTH);
              Busy  <= 1'b1;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (Flush) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= next_iter;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          Busy  <= 1'b0;
          state <= IDLE;
          if (!Flush) begin
            {Hi, Lo} <= wb;
            Done     <= 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed + small random bench for mdu_iterative (WIDTH=32), expected
// HI/LO values queued at issue and compared at Done.
module tb_mdu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, Start, Flush;
  logic [2:0]   MDOp;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  int passed = 0;
  int total  = 0;
  logic [63:0] sb[$];
  logic [31:0] mhi = '0, mlo = '0;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .MDOp(MDOp), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'b000: return {32'b0, a} * {32'b0, b};
      3'b001: return 64'(sa * sbv);
      3'b010: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'b011: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'b110: return hl + {32'b0, a} * {32'b0, b};
      3'b111: return hl + 64'(sa * sbv);
      default: return hl;
    endcase
  endfunction

  // Issue one iterative op; optionally re-assert Start at busy cycle inj.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    logic [63:0] e, got;
    int n;
    sb.push_back(model(op, a, b, {mhi, mlo}));
    @(negedge clk); Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    @(negedge clk); Start = 1'b0; SrcA = ~a; SrcB = ~b;
    n = 0;
    while (!Done && n < 3 * W) begin
      if (Busy) n++;
      if (inj != 0 && n == inj) begin
        Start = 1'b1; MDOp = 3'b000; SrcA = 32'h5; SrcB = 32'h3;
      end else Start = 1'b0;
      @(negedge clk);
    end
    Start = 1'b0;
    chk({tag, "_done"}, 64'(Done), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, "_busy_low"}, 64'(Busy), 64'(0));
    got = {Hi, Lo};
    e = sb.pop_front();
    chk({tag, "_hilo"}, got, e);
    mhi = e[63:32]; mlo = e[31:0];
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(Done), 64'(0));
  endtask

  task automatic mt(input string tag, input logic hi_sel, input logic [31:0] v);
    @(negedge clk); Start = 1'b1; MDOp = hi_sel ? 3'b100 : 3'b101; SrcA = v;
    @(negedge clk); Start = 1'b0;
    if (hi_sel) mhi = v; else mlo = v;
    chk({tag, "_hilo"}, {Hi, Lo}, {mhi, mlo});
    chk({tag, "_busy"}, 64'(Busy), 64'(0));
    chk({tag, "_done"}, 64'(Done), 64'(0));
  endtask

  // Expect neither Busy nor Done for a number of cycles.
  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (Done || Busy) seen++;
    end
    chk(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Flush = 1'b0; MDOp = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {Hi, Lo}, 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    rst = 1'b0;

    run_op("mult",   3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    run_op("multu",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    run_op("div",    3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("divu0",  3'b010, 32'h0000_0007, 32'h0000_0000, 0);
    run_op("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div0s",  3'b011, 32'h8000_0003, 32'h0000_0000, 0);
    run_op("divneg", 3'b011, 32'h0000_0064, 32'hFFFF_FFF9, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      run_op("rand", op, a, b, 0);
    end

    mt("mthi", 1'b1, 32'h0000_1234);
    mt("mtlo", 1'b0, 32'h0000_5678);

    // Flush mid-iteration
    @(negedge clk); Start = 1'b1; MDOp = 3'b010; SrcA = 32'd100; SrcB = 32'd3;
    @(negedge clk); Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk); Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'(0));
    quiet("flush_quiet", 40);
    chk("flush_hilo", {Hi, Lo}, {32'h0000_1234, 32'h0000_5678});

    // Flush exactly in the FIX cycle suppresses write-back
    @(negedge clk); Start = 1'b1; MDOp = 3'b001; SrcA = 32'h0000_0009; SrcB = 32'h0000_0009;
    @(negedge clk); Start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fixflush_busy_pre", 64'(Busy), 64'(1));
    Flush = 1'b1;
    @(negedge clk); Flush = 1'b0;
    chk("fixflush_done", 64'(Done), 64'(0));
    chk("fixflush_busy", 64'(Busy), 64'(0));
    chk("fixflush_hilo", {Hi, Lo}, {32'h0000_1234, 32'h0000_5678});

    // Flush with Start in IDLE drops the Start
    @(negedge clk); Start = 1'b1; Flush = 1'b1; MDOp = 3'b001; SrcA = 32'h3; SrcB = 32'h3;
    @(negedge clk); Start = 1'b0; Flush = 1'b0;
    chk("idleflush_busy", 64'(Busy), 64'(0));
    quiet("idleflush_quiet", 40);
    chk("idleflush_hilo", {Hi, Lo}, {32'h0000_1234, 32'h0000_5678});

    // Async reset mid-multiply
    @(negedge clk); Start = 1'b1; MDOp = 3'b001; SrcA = 32'h3; SrcB = 32'h5;
    @(negedge clk); Start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_hilo", {Hi, Lo}, 64'(0));
    chk("midrst_busy", 64'(Busy), 64'(0));
    mhi = '0; mlo = '0;
    @(negedge clk); rst = 1'b0;
    quiet("midrst_quiet", 40);

    mt("mthi0", 1'b1, 32'h0000_0000);
    mt("mtlof", 1'b0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 3'b110, 32'h0000_0001, 32'h0000_0001, 0);
    chk("maddu_val", {Hi, Lo}, {32'h0000_0001, 32'h0000_0000});
    run_op("madd",  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    chk("madd_val", {Hi, Lo}, {32'h0000_0000, 32'hFFFF_FFFF});
`else
    @(negedge clk); Start = 1'b1; MDOp = 3'b110; SrcA = 32'h1; SrcB = 32'h1;
    @(negedge clk); Start = 1'b0;
    chk("maddnop_busy", 64'(Busy), 64'(0));
    quiet("maddnop_quiet", 40);
    chk("maddnop_hilo", {Hi, Lo}, {32'h0000_0000, 32'hFFFF_FFFF});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
